fir_scan_capture: RTL and testbench
===================================

# fir_scan_capture

Scan-side receiver for the adaptive FIR's serial readback. On `start` it asserts `scan_en` for exactly the number of cycles the FIR needs to rotate every tap out once. It deserialises the FIR's two LSB-first 26-bit streams (`scan_out_x`, `scan_out_w`) into parallel words and presents one `x`/`w` pair per tap with a valid strobe. It sits between the FIR and the debug/readback logic and is the only driver of the FIR's `scan_en`.

## Interface
- `TAPS`, 256, number of FIR taps; also the number of words captured per run
- `M`, 8, log2(TAPS); width of the tap index
- `clk` in 1: system clock, shared with the FIR
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: request a full readback; single-cycle pulse or level
- `fir_act` in 1: FIR busy flag; `start` is ignored while it is high
- `scan_in_x` in 1: connects to FIR `scan_out_x`
- `scan_in_w` in 1: connects to FIR `scan_out_w`
- `scan_en` out 1: registered; connects to FIR `scan_en`
- `word_x` out 16: captured x sample, frame bits [15:0]
- `word_w` out 26: captured weight, full frame
- `word_idx` out M: FIR tap index of the current word
- `word_valid` out 1: one-cycle strobe per captured pair
- `busy` out 1: high from the accepting edge until `done`
- `done` out 1: one-cycle pulse, coincident with the last `word_valid`
- `frame_err` out 1: sticky; any x frame had bits [25:16] that were not all equal to bit 15

## Operation
- Frame format:
  - 26 bits per frame, LSB first.
  - The x frame is the 16-bit sample sign-extended to 26 bits.
  - The w frame is the raw 26-bit weight.
- Word order: the FIR emits tap TAPS-1 first and tap 0 last.
  - Word n therefore has `word_idx` = TAPS-1-n.
  - After the full run the FIR register contents are back in their original order.
- FIR precondition: the FIR's internal scan counter is 0 at `start`. This holds because this block always runs whole frames.
- States:
  - IDLE: `scan_en`=0.
    - On `start && !fir_act`: go to LEAD; set `scan_en`<=1, `busy`<=1, `frame_err`<=0; clear `bit_cnt` and `word_cnt`.
  - LEAD: one cycle with no sampling, then go to CAPTURE. This absorbs the FIR's load edge.
  - CAPTURE: sample both inputs every edge into 26-bit shift registers (MSB insert).
    - `bit_cnt` counts 0..25.
    - At `bit_cnt`==25:
      - load `word_w` = {`scan_in_w`, shreg_w[25:1]}; load `word_x` from bits [15:0] of the assembled x frame;
      - set `word_idx` = TAPS-1-`word_cnt` and pulse `word_valid`;
      - set `frame_err` if assembled x[25:16] is not all equal to x[15];
      - increment `word_cnt` and reset `bit_cnt` to 0.
    - At `word_cnt`==TAPS-1 with `bit_cnt`==24: set `scan_en`<=0. The FIR must see exactly 26·TAPS edges with `scan_en`=1.
    - On the final word (`word_cnt`==TAPS-1, `bit_cnt`==25): pulse `done`, set `busy`<=0, go to IDLE.
- There is no abort. `start` is ignored outside IDLE.
- Reset values:
  - `scan_en`, `word_valid`, `done`, `busy`, `frame_err` = 0.
  - `word_x`, `word_w`, `word_idx` = 0.
  - State IDLE; counters 0.
- Reset mid-run: everything returns to IDLE immediately. The FIR shares `rst_n`, so its scan counter also clears, and no partial state survives.

## Timing
- Let S be the edge that accepts `start`. `scan_en` is high from after edge S through edge S+26·TAPS inclusive.
- Bit k of word n is sampled at edge S+2+26n+k.
- `word_valid` for word n is high in the cycle after edge S+27+26n. The first word appears 27 cycles after `scan_en` rises.
- `done` and the last `word_valid` are high after edge S+26·TAPS+1. `busy` is high for 26·TAPS+1 cycles.
- The final bit is sampled with `scan_en` already low. The FIR shift register holds its value, so the sample is valid.
- A new `start` is accepted no earlier than the edge after `done`. The minimum start-to-start interval is 26·TAPS+2 cycles.
- Outputs `word_x`, `word_w`, `word_idx` hold their values until the next word is loaded.

## Test plan
- TAPS=4, M=2, FIR model preloaded with x={1,-2,0x7FFF,-0x8000} and w={0x0000001,0x3FFFFFF,0x2000000,0x1555555} for taps 0..3, then `start` → four `word_valid` strobes at cycles S+27, +53, +79, +105:
  - `word_idx` reads 3,2,1,0 and the values match;
  - `done` is high with the last strobe;
  - `frame_err`=0;
  - FIR contents are unchanged afterwards.
- Count `scan_en` high cycles with TAPS=4 → exactly 104; the FIR scan counter is 0 after the run; a second back-to-back run gives identical words.
- `start` held high with `fir_act`=1 for 10 cycles, then `fir_act` drops → accepted on the first edge with `fir_act`=0; `start` pulsed during `busy` → ignored, and only TAPS words are emitted.
- Force the x stream frame for tap 2 to 0x0008000 (bit15=1, upper bits 0) → `frame_err` rises with that word's strobe, stays set through `done`, and clears on the next accepted `start`.
- Assert `rst_n` low at cycle S+60 → `scan_en`, `busy` and `word_valid` are 0 immediately; after release a fresh `start` captures all words correctly.
- TAPS=256 default with random FIR contents → 256 words in order 255..0, `done` at S+6657, all values match.

Source files
------------

// File: rtl/fir_scan_capture.sv
// fir_scan_capture: drives the FIR scan_en for one full rotation of all taps and
// deserialises the two LSB-first 26-bit scan streams into per-tap x/w words.
// Words come out highest tap first; the FIR ends the run in its original order.
module fir_scan_capture #(
   parameter int TAPS = 256,
   parameter int M    = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         fir_act,
   input  logic         scan_in_x,
   input  logic         scan_in_w,
   output logic         scan_en,
   output logic [15:0]  word_x,
   output logic [25:0]  word_w,
   output logic [M-1:0] word_idx,
   output logic         word_valid,
   output logic         busy,
   output logic         done,
   output logic         frame_err
);

   typedef enum logic [1:0] {IDLE, LEAD, CAPTURE} state_t;

   localparam logic [M-1:0] LAST = M'(TAPS - 1);

   state_t       state;
   logic [4:0]   bit_cnt;
   logic [M-1:0] word_cnt;
   // Bits 0..24 of the frame in flight; bit 25 arrives live on the last edge.
   logic [24:0]  shreg_x;
   logic [24:0]  shreg_w;
   logic [25:0]  asm_x;
   logic [25:0]  asm_w;

   // Full frames as they stand on the edge that samples bit 25.
   assign asm_x = {scan_in_x, shreg_x};
   assign asm_w = {scan_in_w, shreg_w};

   // Sequencer: scan_en window, bit/word counting, word load and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         shreg_x    <= '0;
         shreg_w    <= '0;
         scan_en    <= 1'b0;
         word_x     <= '0;
         word_w     <= '0;
         word_idx   <= '0;
         word_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !fir_act) begin
                  state     <= LEAD;
                  scan_en   <= 1'b1;
                  busy      <= 1'b1;
                  frame_err <= 1'b0;
                  bit_cnt   <= '0;
                  word_cnt  <= '0;
               end
            end
            // The FIR loads its first frame on this edge; nothing valid yet.
            LEAD: state <= CAPTURE;
            CAPTURE: begin
               shreg_x <= {scan_in_x, shreg_x[24:1]};
               shreg_w <= {scan_in_w, shreg_w[24:1]};
               // Drop scan_en one edge early: the FIR then holds the last bit
               // steady for the final sample and has seen exactly 26*TAPS edges.
               if (word_cnt == LAST && bit_cnt == 5'd24)
                  scan_en <= 1'b0;
               if (bit_cnt == 5'd25) begin
                  word_x     <= asm_x[15:0];
                  word_w     <= asm_w;
                  word_idx   <= LAST - word_cnt;
                  word_valid <= 1'b1;
                  if (asm_x[25:16] != {10{asm_x[15]}})
                     frame_err <= 1'b1;
                  word_cnt   <= word_cnt + 1'b1;
                  bit_cnt    <= '0;
                  if (word_cnt == LAST) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_scan_capture.sv
// tb_fir_scan_capture: directed bench with a behavioural 4-tap FIR scan model.
module tb_fir_scan_capture;

   localparam int TAPS = 4;
   localparam int M    = 2;
   localparam int FL   = 26 * TAPS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, fir_act;
   logic         scan_in_x, scan_in_w;
   logic         scan_en;
   logic [15:0]  word_x;
   logic [25:0]  word_w;
   logic [M-1:0] word_idx;
   logic         word_valid, busy, done, frame_err;

   int npass = 0;
   int ntot  = 0;
   int cyc   = 0;

   // FIR model state
   logic [15:0] xv [TAPS];
   logic [25:0] wv [TAPS];
   logic [25:0] fx [TAPS];
   logic [25:0] fw [TAPS];
   logic [25:0] sr_x, sr_w;
   int          fcnt;
   logic        preload, inj;

   fir_scan_capture #(.TAPS(TAPS), .M(M)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .fir_act(fir_act),
      .scan_in_x(scan_in_x), .scan_in_w(scan_in_w), .scan_en(scan_en),
      .word_x(word_x), .word_w(word_w), .word_idx(word_idx),
      .word_valid(word_valid), .busy(busy), .done(done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIR scan model: on every scan_en edge either load the top tap's frame
   // (rotating the taps) or shift the frame right by one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt <= 0;
         sr_x <= '0;
         sr_w <= '0;
      end else if (preload) begin
         for (int i = 0; i < TAPS; i++) begin
            fx[i] <= {{10{xv[i][15]}}, xv[i]};
            fw[i] <= wv[i];
         end
         fcnt <= 0;
      end else if (scan_en) begin
         if (fcnt % 26 == 0) begin
            sr_x <= (inj && (fcnt / 26 == 1)) ? 26'h0008000 : fx[TAPS-1];
            sr_w <= fw[TAPS-1];
            for (int i = 1; i < TAPS; i++) begin
               fx[i] <= fx[i-1];
               fw[i] <= fw[i-1];
            end
            fx[0] <= fx[TAPS-1];
            fw[0] <= fw[TAPS-1];
         end else begin
            sr_x <= sr_x >> 1;
            sr_w <= sr_w >> 1;
         end
         fcnt <= (fcnt == FL - 1) ? 0 : fcnt + 1;
      end
   end

   assign scan_in_x = sr_x[0];
   assign scan_in_w = sr_w[0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Raise start at a negedge; returns the number of the accepting edge.
   task automatic kick(output int s);
      start = 1'b1;
      s = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Watch one run from the negedge after the accepting edge s.
   // pulse_at >= 0 pulses start that many cycles into the run.
   task automatic monitor(input int s, input bit exp_err, input int pulse_at);
      int n = 0;
      int en = 0;
      logic [15:0] ex;
      chk("busy_on", busy, 1'b1);
      chk("err_clr", frame_err, 1'b0);
      for (int c = 0; c < FL + 40; c++) begin
         if (c > 0) @(negedge clk);
         start = (c == pulse_at);
         if (scan_en) en++;
         if (word_valid) begin
            ex = (exp_err && n == 1) ? 16'h8000 : xv[TAPS-1-n];
            chk($sformatf("w%0d_cyc", n), cyc - s, 27 + 26 * n);
            chk($sformatf("w%0d_idx", n), word_idx, TAPS - 1 - n);
            chk($sformatf("w%0d_x", n), word_x, ex);
            chk($sformatf("w%0d_w", n), word_w, wv[TAPS-1-n]);
            chk($sformatf("w%0d_done", n), done, n == TAPS - 1);
            chk($sformatf("w%0d_err", n), frame_err, exp_err && n >= 1);
            n++;
         end
         if (done) break;
      end
      start = 1'b0;
      chk("nwords", n, TAPS);
      chk("scan_en_cycles", en, FL);
      chk("fir_cnt", fcnt, 0);
      for (int i = 0; i < TAPS; i++) begin
         chk($sformatf("fir_x%0d", i), fx[i], {{10{xv[i][15]}}, xv[i]});
         chk($sformatf("fir_w%0d", i), fw[i], wv[i]);
      end
   endtask

   initial begin
      int s;
      xv[0] = 16'h0001;     xv[1] = 16'hFFFE;     xv[2] = 16'h7FFF;     xv[3] = 16'h8000;
      wv[0] = 26'h0000001;  wv[1] = 26'h3FFFFFF;  wv[2] = 26'h2000000;  wv[3] = 26'h1555555;
      rst_n = 1'b0; start = 1'b0; fir_act = 1'b0; preload = 1'b0; inj = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_scan_en", scan_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_valid", word_valid, 1'b0);
      chk("rst_err", frame_err, 1'b0);
      chk("rst_x", word_x, 16'h0);
      chk("rst_w", word_w, 26'h0);
      chk("rst_idx", word_idx, 2'd0);
      rst_n = 1'b1;
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      @(negedge clk);

      // Basic run, then a back-to-back run started on the edge after done.
      kick(s); monitor(s, 1'b0, -1);
      kick(s); monitor(s, 1'b0, -1);
      chk("idle_busy", busy, 1'b0);

      // start held as a level while the FIR is busy, then fir_act drops.
      repeat (2) @(negedge clk);
      start = 1'b1; fir_act = 1'b1;
      repeat (10) @(negedge clk);
      chk("act_busy", busy, 1'b0);
      chk("act_scan_en", scan_en, 1'b0);
      fir_act = 1'b0;
      s = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      chk("act_scan_en_on", scan_en, 1'b1);
      // Extra start pulse mid-run must be ignored.
      monitor(s, 1'b0, 40);
      repeat (3) @(negedge clk);
      chk("no_rerun", busy, 1'b0);

      // Bad sign extension in the frame for tap 2.
      inj = 1'b1;
      kick(s); monitor(s, 1'b1, -1);
      inj = 1'b0;
      repeat (3) @(negedge clk);
      chk("err_sticky", frame_err, 1'b1);
      kick(s); monitor(s, 1'b0, -1);

      // Reset mid-run.
      kick(s);
      for (int c = 0; c < 100 && cyc < s + 60; c++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_scan_en", scan_en, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valid", word_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      @(negedge clk);
      kick(s); monitor(s, 1'b0, -1);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
